// File: rtl/baby_bridge_pkg.sv
// ---------------------------------------------------------------------------
// baby_bridge_pkg
// Shared definitions for the Manchester Baby RAM bridge:
//   - bridge_state_e : transfer FSM states
//   - BYTES_PER_WORD : external bytes per CPU word
//   - CMD_RW_BIT / CMD_ADDR_LSB / CMD_ADDR_W : command byte layout
//   - TMO_W          : width of the per-byte handshake timeout counter
//   - build_cmd()    : assembles the command byte {rw, 2'b00, addr[4:0]}
// ---------------------------------------------------------------------------
package baby_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_BYTE = 3'd2,
        TURN    = 3'd3,
        RD_BYTE = 3'd4,
        DONE    = 3'd5
    } bridge_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CMD_W          = 8;
    localparam int CMD_RW_BIT     = 7;
    localparam int CMD_ADDR_LSB   = 0;
    localparam int CMD_ADDR_W     = 5;
    localparam int TMO_W          = 8;

    // Command byte: bit 7 = rw (1 = write), bits 6:5 reserved zero,
    // bits 4:0 = word address.
    function automatic logic [CMD_W-1:0] build_cmd(
        input logic                  rw,
        input logic [CMD_ADDR_W-1:0] addr
    );
        logic [CMD_W-1:0] cmd;
        cmd                                = '0;
        cmd[CMD_RW_BIT]                    = rw;
        cmd[CMD_ADDR_LSB +: CMD_ADDR_W]    = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/baby_word_shifter.sv
// ---------------------------------------------------------------------------
// baby_word_shifter
// One CPU word held as a set of byte lanes. Used by the bridge both to
// serialise write data onto the byte bus and to assemble read data.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n_i  in   asynchronous active-low reset, clears the word
//   load_en    in   parallel load of load_word (has priority over insert)
//   load_word  in   WORD_W word to load
//   ins_en     in   write ins_byte into lane idx
//   idx        in   lane index for both select and insert
//   ins_byte   in   byte to insert
//   sel_byte   out  lane idx of the stored word
//   word_ins   out  stored word with ins_byte merged into lane idx when
//                   ins_en is high, i.e. the value the register takes next;
//                   lets the caller capture a complete word on the same edge
//                   as the final byte arrives
// ---------------------------------------------------------------------------
module baby_word_shifter #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n_i,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_word,
    input  logic              ins_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] ins_byte,
    output logic [BYTE_W-1:0] sel_byte,
    output logic [WORD_W-1:0] word_ins
);

    localparam int NUM_LANES = WORD_W / BYTE_W;

    logic [WORD_W-1:0] word_reg;
    logic [BYTE_W-1:0] lane [NUM_LANES];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(gi);

            assign lane[gi] = word_reg[gi*BYTE_W +: BYTE_W];

            assign word_ins[gi*BYTE_W +: BYTE_W] =
                (ins_en && (idx == LANE_IDX)) ? ins_byte
                                              : word_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign sel_byte = lane[idx];

    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            word_reg <= '0;
        end else if (load_en) begin
            word_reg <= load_word;
        end else if (ins_en) begin
            word_reg <= word_ins;
        end
    end

endmodule

// File: rtl/baby_ram_bridge.sv
// ---------------------------------------------------------------------------
// baby_ram_bridge
// Acts as the Manchester Baby core's store. Each 32-bit word access from
// the core becomes a byte-serial transaction on an 8-bit external bus:
//   write: command byte, then four data bytes LSB first
//   read : command byte, one bus-turnaround cycle, then four bytes in
// The core is stalled until cpu_ready_o pulses. A per-byte handshake
// timeout ends a stuck transfer and raises a sticky err_o.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n_i    in   asynchronous active-low reset
//   cpu_req_i    in   access request (level, sampled only in IDLE)
//   cpu_rw_en_i  in   0 = read, 1 = write
//   cpu_addr_i   in   word address
//   cpu_data_i   in   write data
//   cpu_data_o   out  read data, held until the next read completes
//   cpu_ready_o  out  one-cycle completion pulse
//   ext_data_o   out  byte driven to external memory
//   ext_oe_o     out  bridge drives the shared bus pins
//   ext_valid_o  out  ext_data_o carries a valid byte
//   ext_ready_i  in   external side accepts ext_data_o this cycle
//   ext_data_i   in   byte from external memory
//   ext_valid_i  in   ext_data_i valid this cycle (always accepted)
//   err_o        out  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module baby_ram_bridge
    import baby_bridge_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int WORD_W         = 32,
    parameter int BYTE_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_rw_en_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_ready_o,
    output logic [BYTE_W-1:0] ext_data_o,
    output logic              ext_oe_o,
    output logic              ext_valid_o,
    input  logic              ext_ready_i,
    input  logic [BYTE_W-1:0] ext_data_i,
    input  logic              ext_valid_i,
    output logic              err_o
);

    localparam int                IDX_W     = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    bridge_state_e     state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic [TMO_W-1:0]  tmo_reg,   tmo_next;
    logic              rw_reg,    rw_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [WORD_W-1:0] rdata_reg, rdata_next;
    logic              err_reg,   err_next;

    // Shifter control / results
    logic              sh_load;
    logic              sh_ins;
    logic [BYTE_W-1:0] sh_sel_byte;
    logic [WORD_W-1:0] sh_word_ins;

    logic [BYTE_W-1:0] cmd_byte;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_hit;
    logic              tmo_abort;

    assign cmd_byte = BYTE_W'(build_cmd(rw_reg, CMD_ADDR_W'(addr_reg)));

    // The counter counts cycles spent waiting; the cycle in which it would
    // reach the limit is the last one tolerated.
    assign tmo_inc  = tmo_reg + 1'b1;
    assign tmo_hit  = (tmo_inc == TMO_LIMIT);

    // ------------------------------------------------------------------
    // Word register: holds write data for serialisation and collects
    // read bytes.
    // ------------------------------------------------------------------
    baby_word_shifter #(
        .WORD_W (WORD_W),
        .BYTE_W (BYTE_W),
        .IDX_W  (IDX_W)
    ) u_shifter (
        .clock     (clock),
        .reset_n_i (reset_n_i),
        .load_en   (sh_load),
        .load_word (cpu_data_i),
        .ins_en    (sh_ins),
        .idx       (idx_reg),
        .ins_byte  (ext_data_i),
        .sel_byte  (sh_sel_byte),
        .word_ins  (sh_word_ins)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            tmo_reg   <= '0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            tmo_reg   <= tmo_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        tmo_next    = tmo_reg;
        rw_next     = rw_reg;
        addr_next   = addr_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        sh_load     = 1'b0;
        sh_ins      = 1'b0;
        tmo_abort   = 1'b0;
        ext_oe_o    = 1'b0;
        ext_valid_o = 1'b0;
        ext_data_o  = '0;
        cpu_ready_o = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cpu_req_i) begin
                    rw_next    = cpu_rw_en_i;
                    addr_next  = cpu_addr_i;
                    sh_load    = 1'b1;
                    idx_next   = '0;
                    tmo_next   = '0;
                    state_next = CMD;
                end
            end

            CMD: begin
                ext_oe_o    = 1'b1;
                ext_valid_o = 1'b1;
                ext_data_o  = cmd_byte;
                // A handshake in the same cycle as the timeout wins.
                if (ext_ready_i) begin
                    tmo_next   = '0;
                    state_next = rw_reg ? WR_BYTE : TURN;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end else begin
                    tmo_next = tmo_inc;
                end
            end

            WR_BYTE: begin
                ext_oe_o    = 1'b1;
                ext_valid_o = 1'b1;
                ext_data_o  = sh_sel_byte;
                if (ext_ready_i) begin
                    tmo_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end else begin
                    tmo_next = tmo_inc;
                end
            end

            TURN: begin
                // Neither side drives the bus this cycle; ext_valid_i is
                // deliberately ignored here.
                state_next = RD_BYTE;
            end

            RD_BYTE: begin
                if (ext_valid_i) begin
                    sh_ins   = 1'b1;
                    tmo_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        // Capture the full word including the byte arriving
                        // on this edge.
                        rdata_next = sh_word_ins;
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end else begin
                    tmo_next = tmo_inc;
                end
            end

            DONE: begin
                cpu_ready_o = 1'b1;
                idx_next    = '0;
                tmo_next    = '0;
                state_next  = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A stuck handshake ends the transfer with an error; a read that
        // never finished returns zero rather than a partial word.
        if (tmo_abort) begin
            state_next = DONE;
            err_next   = 1'b1;
            tmo_next   = '0;
            if (!rw_reg) begin
                rdata_next = '0;
            end
        end
    end

    assign cpu_data_o = rdata_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_baby_ram_bridge.sv
// ---------------------------------------------------------------------------
// tb_baby_ram_bridge
// Bench for baby_ram_bridge: a CPU-side driver issues accesses and pushes
// expected completions into a scoreboard; an external memory model answers
// the byte bus; a monitor pops the scoreboard on every cpu_ready_o pulse.
// ---------------------------------------------------------------------------
module tb_baby_ram_bridge;

    logic        clock;
    logic        reset_n_i;
    logic        cpu_req_i;
    logic        cpu_rw_en_i;
    logic [4:0]  cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_ready_o;
    logic [7:0]  ext_data_o;
    logic        ext_oe_o;
    logic        ext_valid_o;
    logic        ext_ready_i;
    logic [7:0]  ext_data_i;
    logic        ext_valid_i;
    logic        err_o;

    baby_ram_bridge #(
        .ADDR_W         (5),
        .WORD_W         (32),
        .BYTE_W         (8),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clock       (clock),
        .reset_n_i   (reset_n_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_rw_en_i (cpu_rw_en_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_ready_o (cpu_ready_o),
        .ext_data_o  (ext_data_o),
        .ext_oe_o    (ext_oe_o),
        .ext_valid_o (ext_valid_o),
        .ext_ready_i (ext_ready_i),
        .ext_data_i  (ext_data_i),
        .ext_valid_i (ext_valid_i),
        .err_o       (err_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Knobs for the external memory model (written by the driver only)
    int   stall_pct = 0;    // % chance of withholding ready / valid
    int   stall_len = 0;    // forced ready-low cycles on write byte 1
    logic dead_rd   = 1'b0; // never answer read bytes

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
        int          k;
        int          lat;
    } exp_t;

    exp_t        sb[$];   // expected completions
    logic [7:0]  cq[$];   // expected command bytes
    logic [31:0] wq[$];   // expected write words seen by the memory

    // Reference model state
    logic [31:0] ref_mem [32];
    logic [31:0] last_rd;
    logic        err_m;

    function automatic logic [31:0] seed_word(input int i);
        if (i == 31) return 32'h1234_5678;
        return 32'h9E37_79B9 * 32'(i + 1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // External memory model
    // ------------------------------------------------------------------
    initial begin : ext_dev
        logic [31:0] dev_mem [32];
        int          phase;
        int          bcnt;
        int          st_used;
        logic        dev_rw;
        logic [4:0]  dev_a;
        logic [31:0] wacc;
        logic        hold_pend;
        logic [7:0]  hold_b;
        logic        rdy;
        logic [7:0]  ecmd;
        logic [31:0] ew;

        for (int i = 0; i < 32; i++) dev_mem[i] = seed_word(i);
        phase = 0; bcnt = 0; st_used = 0; dev_rw = 0; dev_a = '0;
        wacc = '0; hold_pend = 0; hold_b = '0;
        ext_ready_i = 0; ext_valid_i = 0; ext_data_i = '0;

        forever begin
            @(negedge clock);
            ext_ready_i = 1'b0;
            ext_valid_i = 1'b0;
            ext_data_i  = 8'($urandom);
            if (!reset_n_i || cpu_ready_o) begin
                phase     = 0;
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 32'(ext_valid_o), 32'd1);
                    chk("hold_data", 32'(ext_data_o), 32'(hold_b));
                    hold_pend = 0;
                end
                case (phase)
                    0, 1: begin
                        if (ext_valid_o) begin
                            chk("drive_oe", 32'(ext_oe_o), 32'd1);
                            rdy = ($urandom_range(0, 99) >= stall_pct);
                            if (phase == 1 && bcnt == 1 && st_used < stall_len) begin
                                rdy = 1'b0;
                                st_used++;
                            end
                            ext_ready_i = rdy;
                            if (!rdy) begin
                                hold_pend = 1;
                                hold_b    = ext_data_o;
                            end else if (phase == 0) begin
                                if (cq.size() == 0) begin
                                    chk("cmd_unexpected", 32'(ext_data_o), 32'hFFFF_FFFF);
                                end else begin
                                    ecmd = cq.pop_front();
                                    chk("cmd_byte", 32'(ext_data_o), 32'(ecmd));
                                end
                                dev_rw  = ext_data_o[7];
                                dev_a   = ext_data_o[4:0];
                                bcnt    = 0;
                                st_used = 0;
                                wacc    = '0;
                                phase   = dev_rw ? 1 : 2;
                            end else begin
                                wacc = wacc | (32'(ext_data_o) << (8 * bcnt));
                                bcnt++;
                                if (bcnt == 4) begin
                                    dev_mem[dev_a] = wacc;
                                    if (wq.size() == 0) begin
                                        chk("wr_unexpected", wacc, 32'hFFFF_FFFF);
                                    end else begin
                                        ew = wq.pop_front();
                                        chk("wr_word", wacc, ew);
                                    end
                                    phase = 0;
                                end
                            end
                        end
                    end
                    2: begin
                        chk("turn_oe", 32'(ext_oe_o), 32'd0);
                        chk("turn_valid", 32'(ext_valid_o), 32'd0);
                        // Junk during turnaround must not be captured.
                        ext_valid_i = 1'b1;
                        ext_data_i  = 8'hA5;
                        phase       = 3;
                    end
                    default: begin
                        if (!dead_rd && $urandom_range(0, 99) >= stall_pct) begin
                            ext_valid_i = 1'b1;
                            ext_data_i  = 8'(dev_mem[dev_a] >> (8 * bcnt));
                            bcnt++;
                            if (bcnt == 4) phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n_i && cpu_ready_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("cpu_data", cpu_data_o, e.data);
                    chk("err", 32'(err_o), 32'(e.err));
                    if (e.lat >= 0) chk("latency", 32'(cyc - e.k), 32'(e.lat));
                    $display("txn %s addr=%0d data=%h err=%0d lat=%0d",
                             e.rw ? "WR" : "RD", e.addr, cpu_data_o, err_o, cyc - e.k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-side driver
    // ------------------------------------------------------------------
    task automatic issue(input logic rw, input logic [4:0] a, input logic [31:0] d,
                         input int lat, input logic tmo);
        exp_t e;
        cpu_req_i   = 1'b1;
        cpu_rw_en_i = rw;
        cpu_addr_i  = a;
        cpu_data_i  = d;
        e.rw   = rw;
        e.addr = a;
        e.k    = cyc;
        e.lat  = lat;
        if (tmo) err_m = 1'b1;
        if (rw) begin
            ref_mem[a] = d;
            wq.push_back(d);
        end else begin
            last_rd = tmo ? 32'd0 : ref_mem[a];
        end
        e.data = last_rd;
        e.err  = err_m;
        sb.push_back(e);
        cq.push_back(rw ? (8'd128 + 8'(a)) : 8'(a));
        @(negedge clock);
        // Request has been sampled; scramble the bus to catch late sampling.
        cpu_req_i   = 1'b0;
        cpu_rw_en_i = 1'($urandom);
        cpu_addr_i  = 5'($urandom);
        cpu_data_i  = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!cpu_ready_o && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", 32'(cpu_ready_o), 32'd1);
        @(negedge clock);
    endtask

    task automatic access(input logic rw, input logic [4:0] a, input logic [31:0] d,
                          input int lat, input logic tmo);
        issue(rw, a, d, lat, tmo);
        wait_done();
    endtask

    task automatic random_accesses(input int n);
        logic rw;
        int   lat;
        for (int i = 0; i < n; i++) begin
            rw  = 1'($urandom);
            lat = (stall_pct == 0) ? (rw ? 6 : 7) : -1;
            access(rw, 5'($urandom_range(0, 31)), $urandom, lat, 1'b0);
        end
    endtask

    initial begin : driver
        for (int i = 0; i < 32; i++) ref_mem[i] = seed_word(i);
        last_rd     = '0;
        err_m       = 1'b0;
        reset_n_i   = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_rw_en_i = 1'b0;
        cpu_addr_i  = '0;
        cpu_data_i  = '0;

        repeat (3) @(negedge clock);
        chk("rst_cpu_data", cpu_data_o, 32'd0);
        chk("rst_ready", 32'(cpu_ready_o), 32'd0);
        chk("rst_ext_data", 32'(ext_data_o), 32'd0);
        chk("rst_oe", 32'(ext_oe_o), 32'd0);
        chk("rst_valid", 32'(ext_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge clock);

        // Directed write / reads
        access(1'b1, 5'd3, 32'hDEAD_BEEF, 6, 1'b0);
        access(1'b0, 5'd31, 32'd0, 7, 1'b0);
        access(1'b0, 5'd3, 32'd0, 7, 1'b0);

        // Backpressure: ready withheld 3 cycles on write byte 1
        stall_len = 3;
        access(1'b1, 5'd10, 32'hA1B2_C3D4, 9, 1'b0);
        stall_len = 0;
        access(1'b0, 5'd10, 32'd0, 7, 1'b0);

        // Back-to-back random traffic, deterministic latency
        random_accesses(20);

        // Random handshake gaps on both directions
        stall_pct = 30;
        random_accesses(30);
        stall_pct = 0;

        // Dead memory on a read: timeout, zero data, sticky error
        dead_rd = 1'b1;
        access(1'b0, 5'd5, 32'd0, 258, 1'b1);
        dead_rd = 1'b0;
        random_accesses(4);
        access(1'b0, 5'd31, 32'd0, 7, 1'b0);

        // Reset in the middle of a read after two bytes
        issue(1'b0, 5'd7, 32'd0, 7, 1'b0);
        repeat (4) @(negedge clock);
        sb.delete();
        cq.delete();
        reset_n_i = 1'b0;
        #1;
        chk("midrst_cpu_data", cpu_data_o, 32'd0);
        chk("midrst_ready", 32'(cpu_ready_o), 32'd0);
        chk("midrst_oe", 32'(ext_oe_o), 32'd0);
        chk("midrst_valid", 32'(ext_valid_o), 32'd0);
        chk("midrst_ext_data", 32'(ext_data_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        err_m   = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge clock);
        reset_n_i = 1'b1;
        @(negedge clock);
        access(1'b0, 5'd7, 32'd0, 7, 1'b0);
        random_accesses(4);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baby_ram_bridge.md
Name: baby_ram_bridge

Overview:
- Sits directly downstream of the Manchester Baby core's RAM port and acts as the core's store.
- Converts each 32-bit word access into a byte-serial transaction on an 8-bit external bus; the 32x32 store itself lives off-chip.
- Holds the core stalled (cpu_ready_o low) until the transfer completes.
- Provides a timeout with a sticky error flag so a dead external memory cannot hang the core silently.

Parameters:
ADDR_W, 5, CPU word address width (32 words)
WORD_W, 32, CPU word width; must be 4*BYTE_W
BYTE_W, 8, external bus width
TIMEOUT_CYCLES, 255, max idle cycles waiting on any single external byte handshake

Ports:
clock  in  1  system clock, rising edge
reset_n_i  in  1  asynchronous, active-low reset
cpu_req_i  in  1  core requests an access (level, sampled in IDLE only)
cpu_rw_en_i  in  1  0 = read, 1 = write (core's ram_rw_en_o)
cpu_addr_i  in  ADDR_W  word address (core's ram_addr_o)
cpu_data_i  in  WORD_W  write data (core's ram_data_o)
cpu_data_o  out  WORD_W  read data (to core's ram_data_i)
cpu_ready_o  out  1  one-cycle completion pulse / stall release
ext_data_o  out  BYTE_W  byte driven to external memory
ext_oe_o  out  1  1 = bridge drives shared bus pins
ext_valid_o  out  1  ext_data_o holds a valid byte
ext_ready_i  in  1  external side accepts ext_data_o this cycle
ext_data_i  in  BYTE_W  byte from external memory
ext_valid_i  in  1  ext_data_i valid this cycle (always accepted)
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync deassert handled at top level): state IDLE; cpu_data_o=0, cpu_ready_o=0, ext_data_o=0, ext_oe_o=0, ext_valid_o=0, err_o=0; counters and shift register cleared. Reset mid-transfer aborts it immediately and leaves no ready pulse.
- Command byte: {rw, 2'b00, addr[4:0]}. Data bytes are LSB-first (byte0 = bits 7:0).
- IDLE: if cpu_req_i=1, latch rw, addr and data, then go to CMD. No other input is sampled.
- CMD: ext_oe_o=1, ext_valid_o=1, ext_data_o=command byte. On ext_ready_i=1, go to WR_BYTE (write) or TURN (read).
- WR_BYTE: ext_oe_o=1, ext_valid_o=1, ext_data_o=current byte. Each ext_ready_i=1 advances the byte index 0..3. Handshake on byte 3 goes to DONE.
- TURN: exactly one cycle with ext_oe_o=0 and ext_valid_o=0 (bus turnaround), then go to RD_BYTE.
- RD_BYTE: ext_oe_o=0. Each ext_valid_i=1 shifts ext_data_i into the byte slot given by the index. ext_valid_i during TURN is ignored. The 4th byte goes to DONE, and the assembled word loads cpu_data_o on that same edge.
- DONE: cpu_ready_o=1 for exactly one cycle, then IDLE. The core must drop cpu_req_i on the edge where it sees cpu_ready_o; a req still high in the following IDLE is a new access.
- cpu_data_o holds its value until the next read completes. Writes never change it.
- Latency from the req-sampling edge k, with the external side always ready/valid:
  - write: CMD k+1, bytes k+2..k+5, ready high in cycle k+6 (6-cycle stall).
  - read: CMD k+1, TURN k+2, bytes k+3..k+6, ready high in cycle k+7.
- Backpressure: ext_valid_o and ext_data_o stay stable until ext_ready_i is seen.
- Timeout: an 8-bit counter increments each cycle in CMD, WR_BYTE or RD_BYTE without a handshake, and clears on every handshake and on entry to CMD. When it reaches TIMEOUT_CYCLES: go to DONE and set err_o=1 (cleared only by reset). A timed-out read forces cpu_data_o=0.
- Simultaneous handshake and timeout in the same cycle: the handshake wins.
- Byte index wraps only through DONE, never within a transfer.

Decomposition:
- Package baby_bridge_pkg holds:
  - state enum {IDLE, CMD, WR_BYTE, TURN, RD_BYTE, DONE}
  - BYTES_PER_WORD=4
  - CMD_RW_BIT=7
  - CMD_ADDR_LSB=0
  - command-byte build function
- One sub-module: baby_word_shifter, a WORD_W register with parallel load, byte select out (by index) and byte insert in (by index). The FSM, timeout counter and err_o stay in the top.

Test Plan:
- Write: addr=5'd3, data=32'hDEADBEEF, ext_ready_i=1 -> ext_data_o sequence 8'h83, EF, BE, AD, DE with ext_oe_o=1; cpu_ready_o pulses at k+6.
- Read: addr=5'd31; model answers 8'h78,56,34,12 back-to-back -> ext_data_o=8'h1F, one TURN cycle with oe=0, cpu_data_o=32'h12345678 and cpu_ready_o at k+7.
- Backpressure: ext_ready_i low for 3 cycles on byte 1 of a write -> ext_data_o held stable throughout, completion at k+9, err_o=0.
- Timeout: read with ext_valid_i never asserted -> DONE after 255 idle cycles in RD_BYTE, cpu_data_o=0, err_o=1 and stays 1 across later successful accesses.
- Reset mid-read after 2 bytes -> all outputs 0 immediately, no ready pulse; next read completes normally.
- Back-to-back write then read with cpu_req_i re-asserted in the IDLE after DONE -> second transfer's CMD one cycle after IDLE, no lost or duplicated access.
